// File: rtl/bk_adder_pkg.sv
// Shared constants and types for the serial wide adder.
// Chunk width, FSM state enum and a counter-width helper.
package bk_adder_pkg;

  localparam int BK_CHUNK_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } bk_ser_state_t;

  function automatic int bk_cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/Brent_Kung_Adder_12Bit.sv
// 12-bit Brent-Kung parallel-prefix adder.
// Carry-in is folded into bit 0 generate.
module Brent_Kung_Adder_12Bit (
  input  logic [11:0] A,
  input  logic [11:0] B,
  input  logic        Cin,
  output logic [11:0] Sum,
  output logic        Cout
);

  logic [11:0] g;
  logic [11:0] p;
  logic [11:0] gg;
  logic [11:0] pp;
  logic [11:0] c;

  // Up-sweep then down-sweep prefix tree over (g,p) pairs
  always_comb begin
    g  = A & B;
    p  = A ^ B;
    gg = g;
    pp = p;
    gg[0] = g[0] | (p[0] & Cin);
    for (int d = 1; d < 12; d = d * 2) begin
      for (int i = 0; i < 12; i++) begin
        if (((i + 1) % (2 * d)) == 0) begin
          gg[i] = gg[i] | (pp[i] & gg[i-d]);
          pp[i] = pp[i] & pp[i-d];
        end
      end
    end
    for (int d = 4; d >= 1; d = d / 2) begin
      for (int i = 0; i < 12; i++) begin
        if ((((i + 1) % (2 * d)) == d) && (i >= 2 * d)) begin
          gg[i] = gg[i] | (pp[i] & gg[i-d]);
          pp[i] = pp[i] & pp[i-d];
        end
      end
    end
    c = {gg[10:0], Cin};
  end

  assign Sum  = p ^ c;
  assign Cout = gg[11];

endmodule

// File: rtl/bk_serial_wide_adder.sv
// Serial wide adder: one 12-bit Brent-Kung pass per cycle, LSB chunk first.
// Optional signed overflow output enabled by BK_SERIAL_OVF_EN.
module bk_serial_wide_adder
  import bk_adder_pkg::*;
#(
  parameter int NUM_CHUNKS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [BK_CHUNK_W*NUM_CHUNKS-1:0] A,
  input  logic [BK_CHUNK_W*NUM_CHUNKS-1:0] B,
  input  logic                           Cin,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [BK_CHUNK_W*NUM_CHUNKS-1:0] Sum,
  output logic                           Cout,
`ifdef BK_SERIAL_OVF_EN
  output logic                           ovf,
`endif
  output logic                           busy
);

  localparam int W  = BK_CHUNK_W * NUM_CHUNKS;
  localparam int CW = bk_cnt_w(NUM_CHUNKS);
  localparam logic [CW-1:0] LAST = CW'(NUM_CHUNKS - 1);

  bk_ser_state_t state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          c_q, c_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [BK_CHUNK_W-1:0] ch_sum;
  logic                  ch_cout;

`ifdef BK_SERIAL_OVF_EN
  logic ovf_q, ovf_d;
`endif

  Brent_Kung_Adder_12Bit u_chunk (
    .A    (a_q[BK_CHUNK_W-1:0]),
    .B    (b_q[BK_CHUNK_W-1:0]),
    .Cin  (c_q),
    .Sum  (ch_sum),
    .Cout (ch_cout)
  );

  // Next-state: accept, per-chunk shift/ripple, hold result until taken
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
`ifdef BK_SERIAL_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          c_d     = Cin;
          cnt_d   = '0;
`ifdef BK_SERIAL_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = ADD;
        end
      end
      ADD: begin
        a_d   = a_q >> BK_CHUNK_W;
        b_d   = b_q >> BK_CHUNK_W;
        sum_d = W'({ch_sum, sum_q} >> BK_CHUNK_W);
        c_d   = ch_cout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
`ifdef BK_SERIAL_OVF_EN
          ovf_d = (a_q[BK_CHUNK_W-1] == b_q[BK_CHUNK_W-1]) &&
                  (ch_sum[BK_CHUNK_W-1] != a_q[BK_CHUNK_W-1]);
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
`ifdef BK_SERIAL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
`ifdef BK_SERIAL_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign Sum       = sum_q;
  assign Cout      = c_q;
`ifdef BK_SERIAL_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
